// File: rtl/leb128_pkg.sv
// leb128_pkg
//   Shared LEB128 definitions for the transmit encoder (pack_u64_stream)
//   and the receive decoder (unpack_u64).
//   Contents:
//     CHUNK_W        payload bits carried per encoded byte
//     CONT_BIT       bit position of the continuation flag in a byte
//     MAX_BYTES_U64  longest encoding of a 64-bit value
//     LEN_W          width of a byte count / byte index
//     leb128_byte_t  one encoded byte, {cont, chunk}
//     enc_state_t    encoder handshake states
//     leb128_is_last termination rule shared by encoder and length helper
//     leb128_enc_len encoded length of a value, for checks and sizing
package leb128_pkg;

  localparam int CHUNK_W       = 7;
  localparam int CONT_BIT      = 7;
  localparam int MAX_BYTES_U64 = 10;
  localparam int LEN_W         = 4;

  // One encoded byte: cont sits at CONT_BIT, chunk holds the 7 payload bits.
  typedef struct packed {
    logic               cont;
    logic [CHUNK_W-1:0] chunk;
  } leb128_byte_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } enc_state_t;

  // A byte is the last one when the remainder after it carries no further
  // information. For the signed form the sign bit of the emitted chunk
  // must also agree with the sign-extension that remains, otherwise a
  // decoder would reconstruct the wrong sign.
  function automatic logic leb128_is_last(input logic [63:0] rem,
                                          input logic [63:0] nxt,
                                          input logic        signed_mode);
    logic result;
    if (!signed_mode) begin
      result = (nxt == '0);
    end else begin
      result = ((nxt == '0) && !rem[CHUNK_W-1]) ||
               ((nxt == '1) &&  rem[CHUNK_W-1]);
    end
    return result;
  endfunction

  // Number of bytes the encoding of value occupies (1..MAX_BYTES_U64).
  function automatic logic [LEN_W-1:0] leb128_enc_len(input logic [63:0] value,
                                                      input logic        signed_mode);
    logic [63:0]      r;
    logic [63:0]      n;
    logic             done;
    logic [LEN_W-1:0] len;
    r    = value;
    len  = '0;
    done = 1'b0;
    for (int k = 0; k < MAX_BYTES_U64; k++) begin
      if (!done) begin
        n    = {{CHUNK_W{signed_mode & r[63]}}, r[63:CHUNK_W]};
        len  = len + LEN_W'(1);
        done = leb128_is_last(r, n, signed_mode);
        r    = n;
      end
    end
    return len;
  endfunction

endpackage

// File: rtl/leb128_enc_step.sv
// leb128_enc_step
//   Combinational single-byte LEB128 encoder step. Given the not-yet-sent
//   remainder of a value it produces the next encoded byte, whether that
//   byte terminates the encoding, and the remainder left after it.
//   Ports:
//     rem_i          remainder still to be encoded
//     signed_mode_i  0 = unsigned LEB128, 1 = signed SLEB128
//     byte_o         encoded byte {continuation, chunk}
//     last_o         byte_o is the final byte of the encoding
//     nxt_o          remainder after byte_o (logical or arithmetic >> 7)
module leb128_enc_step
  import leb128_pkg::*;
(
  input  logic [63:0] rem_i,
  input  logic        signed_mode_i,
  output logic [7:0]  byte_o,
  output logic        last_o,
  output logic [63:0] nxt_o
);

  leb128_byte_t enc_byte;

  // Shift out one chunk; in signed mode the vacated top bits replicate the
  // sign so that negative values converge on all-ones. The continuation
  // flag is simply the inverse of the termination rule.
  always_comb begin
    nxt_o          = {{CHUNK_W{signed_mode_i & rem_i[63]}}, rem_i[63:CHUNK_W]};
    last_o         = leb128_is_last(rem_i, nxt_o, signed_mode_i);
    enc_byte.cont  = !last_o;
    enc_byte.chunk = rem_i[CHUNK_W-1:0];
    byte_o         = enc_byte;
  end

endmodule

// File: rtl/pack_u64_stream.sv
// pack_u64_stream
//   Streaming LEB128 / SLEB128 encoder. Takes one 64-bit word per input
//   handshake and emits its encoding one byte per output handshake, framed
//   with a last flag and a running byte count.
//   Parameters:
//     SIGNED   0 = unsigned LEB128, 1 = signed SLEB128
//   Ports:
//     clk      clock, all state on the rising edge
//     rst      synchronous active-high reset
//     i_data   value to encode, sampled only on accept
//     i_valid  i_data valid
//     i_ready  encoder can take i_data this cycle
//     o_byte   encoded byte, bit7 = continuation, bits6:0 = chunk
//     o_valid  o_byte valid
//     o_ready  downstream accepts o_byte
//     o_last   o_byte is the final byte of the encoding
//     o_len    byte index+1 of the current byte (total length on o_last)
module pack_u64_stream
  import leb128_pkg::*;
#(
  parameter bit SIGNED = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] i_data,
  input  logic        i_valid,
  output logic        i_ready,
  output logic [7:0]  o_byte,
  output logic        o_valid,
  input  logic        o_ready,
  output logic        o_last,
  output logic [3:0]  o_len
);

  enc_state_t       state_q, state_d;
  logic [63:0]      rem_q, rem_d;
  logic [LEN_W-1:0] idx_q, idx_d;

  logic [7:0]  step_byte;
  logic        step_last;
  logic [63:0] step_nxt;
  logic        accept;

  leb128_enc_step u_step (
    .rem_i         (rem_q),
    .signed_mode_i (SIGNED),
    .byte_o        (step_byte),
    .last_o        (step_last),
    .nxt_o         (step_nxt)
  );

  // Outputs are functions of registered state only. In IDLE the remainder
  // and index are held at zero, so byte and length read as zero there.
  always_comb begin
    o_valid = (state_q == ST_EMIT);
    o_last  = o_valid & step_last;
    o_byte  = o_valid ? step_byte : 8'h00;
    o_len   = idx_q;
  end

  // A new word may enter while the final byte of the previous one is
  // being taken, which is what lets consecutive words stream with no gap.
  always_comb begin
    i_ready = !o_valid | (o_ready & o_last);
    accept  = i_valid & i_ready;
  end

  // Next-state logic. An accept while in EMIT can only happen on the
  // completing beat, so it also covers the "completion with a new word
  // waiting" case; without a new word the completing beat returns to IDLE.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    if (accept) begin
      state_d = ST_EMIT;
      rem_d   = i_data;
      idx_d   = LEN_W'(1);
    end else if (o_valid && o_ready) begin
      if (step_last) begin
        state_d = ST_IDLE;
        rem_d   = '0;
        idx_d   = '0;
      end else begin
        rem_d   = step_nxt;
        idx_d   = idx_q + LEN_W'(1);
      end
    end
  end

  // State registers; reset abandons any encoding in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
    end
  end

  // A 64-bit value always terminates within ten bytes; a tenth byte that
  // still wants to continue means the termination rule is broken.
  always_ff @(posedge clk) begin
    if (!rst && o_valid) begin
      assert (step_last || (idx_q < LEN_W'(MAX_BYTES_U64)));
    end
  end

endmodule
